cell3_bist_seq: RTL and testbench
=================================

Name: cell3_bist_seq

Overview:
- Built-in self-test sequencer for a bank of 3-input gf180mcu_osu_sc_gp9t3v3 combinational cells (nor3/and3/or3 and similar).
- Sits directly upstream of the cells under test, driving their A/B/C pins with all 8 input patterns.
- Sits directly downstream of them as well, sampling each cell's Y and checking it against a per-cell expected truth table.
- Reports per-cell fail mask, mismatch count and pass/fail.

Parameters:
- NUM_CELLS, 3, number of cells under test (1..16); all share A/B/C.
- TRUTH, 24'hFE_80_01, expected truth tables, 8 bits per cell. Cell k uses TRUTH[8k+7:8k]; bit p = expected Y for pattern p. Default order: cell0=nor3 (8'h01), cell1=and3 (8'h80), cell2=or3 (8'hFE).
- SETTLE_CYC, 2, cycles each pattern is held before sampling (minimum 1).
- ERR_W, 8, width of mismatch counter.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  single-cycle start request; sampled only in IDLE.
- A  output  1  pattern bit 2 to all cells under test.
- B  output  1  pattern bit 1.
- C  output  1  pattern bit 0.
- Y_IN  input  NUM_CELLS  Y outputs of cells under test; bit k = cell k.
- BUSY  output  1  high in SETTLE/SAMPLE.
- DONE  output  1  one-cycle pulse at end of run.
- PASS  output  1  valid from DONE onward: 1 iff FAIL_MASK==0.
- FAIL_MASK  output  NUM_CELLS  sticky per-cell mismatch flags for the last run.
- ERR_CNT  output  ERR_W  total mismatching cell-samples in the last run, saturating.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state=IDLE; A=B=C=0; BUSY=0; DONE=0; PASS=0; FAIL_MASK=0; ERR_CNT=0; pattern index p=0; settle counter=0.
  - Reset mid-run aborts immediately; no DONE is produced.
- States: IDLE, SETTLE, SAMPLE, FINISH.
- IDLE:
  - A/B/C=0.
  - START=1 → SETTLE next cycle with p=0, counter=0. On that same edge, FAIL_MASK and ERR_CNT clear to 0 and PASS clears to 0.
- SETTLE:
  - {A,B,C}=p[2:0]; counter increments each cycle.
  - When counter==SETTLE_CYC-1 → SAMPLE.
- SAMPLE:
  - {A,B,C} still =p.
  - mismatch[k] = Y_IN[k] XOR TRUTH[8k+p].
  - FAIL_MASK |= mismatch.
  - ERR_CNT += popcount(mismatch), saturating at 2^ERR_W-1 with no wrap.
  - If p==7 → FINISH; else p=p+1, counter=0, → SETTLE.
- FINISH:
  - DONE=1 for exactly this cycle; A/B/C=0.
  - PASS register loads (FAIL_MASK==0) on entry and holds.
  - → IDLE.
- Latency: START sampled at edge 0 → DONE high in cycle 1+8*(SETTLE_CYC+1). Default: cycle 25.
- BUSY=1 in SETTLE and SAMPLE only.
- START is ignored outside IDLE, including the FINISH cycle.
- Results (FAIL_MASK, ERR_CNT, PASS) hold until the next accepted START or reset.
- Y_IN is sampled only in SAMPLE; values in other states have no effect.
- All outputs are registered; no combinational path from Y_IN or START to any output.

Optional Feature:
- Macro CELL3_BIST_MISR_EN.
- When defined:
  - Adds output SIGNATURE[15:0], a 16-bit MISR with polynomial x^16+x^12+x^5+1 and seed 16'hFFFF.
  - Seed loads on accepted START and on reset.
  - In each SAMPLE cycle: shift once, then XOR Y_IN (zero-extended) into the low bits.
  - Holds after FINISH.
- When undefined: no SIGNATURE port, no MISR logic; all other behaviour is identical.

Test Plan:
- Default params, Y_IN driven by ideal nor3/and3/or3 models of A/B/C, START pulse → DONE at cycle 25, PASS=1, FAIL_MASK=3'b000, ERR_CNT=0.
- Cell1 Y stuck-at-0 → FAIL_MASK=3'b010, ERR_CNT=1 (only pattern 7 mismatches), PASS=0.
- Cell2 Y stuck-at-0 → ERR_CNT=7, FAIL_MASK=3'b100. Cell0 stuck-at-1 additionally → ERR_CNT=14, FAIL_MASK=3'b101.
- ERR_W=3, all cells inverted → 24 mismatches saturate ERR_CNT at 7; FAIL_MASK=3'b111.
- Check A/B/C sequence 000,001,...,111, each held 3 cycles. START re-pulsed while BUSY → ignored, DONE still at cycle 25. RST asserted at cycle 10 → next cycle IDLE, all outputs 0, no DONE pulse.
- With CELL3_BIST_MISR_EN and the ideal model, two runs give an identical SIGNATURE. Flipping one Y_IN sample changes SIGNATURE.

Source files
------------

// File: rtl/cell3_bist_seq.sv
// cell3_bist_seq: built-in self-test sequencer for a bank of 3-input
// combinational cells. Drives the shared A/B/C pins through all 8 patterns,
// samples each cell's Y once the pattern has settled and compares it with that
// cell's expected truth table. Reports a sticky per-cell fail mask, a
// saturating mismatch count and a pass flag.
// Optional build macro CELL3_BIST_MISR_EN adds a 16-bit MISR output SIGNATURE
// (x^16+x^12+x^5+1, seed 16'hFFFF) that compacts every sampled Y_IN word.
module cell3_bist_seq #(
    parameter int                       NUM_CELLS  = 3,
    parameter logic [8*NUM_CELLS-1:0]   TRUTH      = 24'hFE_80_01,
    parameter int                       SETTLE_CYC = 2,
    parameter int                       ERR_W      = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 A,
    output logic                 B,
    output logic                 C,
    input  logic [NUM_CELLS-1:0] Y_IN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 PASS,
    output logic [NUM_CELLS-1:0] FAIL_MASK,
`ifdef CELL3_BIST_MISR_EN
    output logic [15:0]          SIGNATURE,
`endif
    output logic [ERR_W-1:0]     ERR_CNT
);

    // Settle counter only has to reach SETTLE_CYC-1; keep at least one bit.
    localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    // Popcount of one sample and the widened sum used for saturation.
    localparam int PC_W  = $clog2(NUM_CELLS + 1);
    localparam int SUM_W = ERR_W + PC_W;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_FINISH
    } state_t;

    state_t                 r_state;
    logic [2:0]             r_pat;
    logic [CNT_W-1:0]       r_cnt;
    logic [2:0]             r_abc;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic [NUM_CELLS-1:0]   r_fail_mask;
    logic [ERR_W-1:0]       r_err_cnt;

    logic [NUM_CELLS-1:0]   w_mismatch;
    logic [PC_W-1:0]        w_popcnt;
    logic [SUM_W-1:0]       w_sum;
    logic [ERR_W-1:0]       w_err_sat;

    // Per-cell comparison of Y against the expected bit for the current pattern.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CELLS; gi++) begin : g_cmp
            localparam logic [7:0] CELL_TT = TRUTH[8*gi +: 8];
            assign w_mismatch[gi] = Y_IN[gi] ^ CELL_TT[r_pat];
        end
    endgenerate

    // Count mismatching cells in this sample and add them with saturation.
    always_comb begin
        w_popcnt = '0;
        for (int k = 0; k < NUM_CELLS; k++) begin
            w_popcnt = w_popcnt + PC_W'(w_mismatch[k]);
        end
        w_sum     = SUM_W'(r_err_cnt) + SUM_W'(w_popcnt);
        w_err_sat = (w_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : w_sum[ERR_W-1:0];
    end

    // Sequencer FSM: every output is a register updated alongside the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_pat       <= 3'd0;
            r_cnt       <= '0;
            r_abc       <= 3'b000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail_mask <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_abc <= 3'b000;
                    if (START) begin
                        r_state     <= S_SETTLE;
                        r_pat       <= 3'd0;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_fail_mask <= '0;
                        r_err_cnt   <= '0;
                        r_pass      <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    r_fail_mask <= r_fail_mask | w_mismatch;
                    r_err_cnt   <= w_err_sat;
                    if (r_pat == 3'd7) begin
                        // Pass is judged on the mask including this last sample.
                        r_state <= S_FINISH;
                        r_abc   <= 3'b000;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= ((r_fail_mask | w_mismatch) == '0);
                    end else begin
                        r_state <= S_SETTLE;
                        r_pat   <= r_pat + 3'd1;
                        r_abc   <= r_pat + 3'd1;
                        r_cnt   <= '0;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CELL3_BIST_MISR_EN
    logic [15:0] r_sig;
    logic [15:0] w_sig_next;

    // One MISR step: Galois shift by x^16+x^12+x^5+1, then fold in the sample.
    assign w_sig_next = {r_sig[14:0], 1'b0}
                      ^ (r_sig[15] ? 16'h1021 : 16'h0000)
                      ^ 16'(Y_IN);

    // Signature reseeds on reset and on an accepted start, updates per sample.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sig <= 16'hFFFF;
        end else if (r_state == S_IDLE && START) begin
            r_sig <= 16'hFFFF;
        end else if (r_state == S_SAMPLE) begin
            r_sig <= w_sig_next;
        end
    end

    assign SIGNATURE = r_sig;
`endif

    assign {A, B, C}  = r_abc;
    assign BUSY       = r_busy;
    assign DONE       = r_done;
    assign PASS       = r_pass;
    assign FAIL_MASK  = r_fail_mask;
    assign ERR_CNT    = r_err_cnt;

endmodule

// File: tb/tb_cell3_bist_seq.sv
// tb_cell3_bist_seq: self-checking bench for cell3_bist_seq. A timeline model
// (cycles since an accepted start) predicts every output each cycle; directed
// runs add literal expectations for DONE timing and final results.
// dut0: default parameters, Y from ideal nor3/and3/or3 with injectable faults.
// dut1: ERR_W=3, every cell inverted, to exercise counter saturation.
module tb_cell3_bist_seq;

    localparam int S       = 2;
    localparam int RUN_LEN = 8 * (S + 1);
    localparam logic [23:0] TRUTH = 24'hFE_80_01;

    typedef struct packed {
        int          t;
        logic [2:0]  fm;
        int          err;
        logic        pass;
        logic [15:0] sig;
    } model_t;

    logic CLK = 1'b0;
    logic RST;
    logic START;

    logic       a0, b0, c0, busy0, done0, pass0;
    logic [2:0] y0, fm0, ideal0, sa0, sa1;
    logic [7:0] err0;
    logic       flip;
    logic       a1, b1, c1, busy1, done1, pass1;
    logic [2:0] y1, fm1;
    logic [2:0] err1;
`ifdef CELL3_BIST_MISR_EN
    logic [15:0] sig0, sig1;
`endif

    int     n_vec = 0;
    int     n_err = 0;
    logic   chk_en = 1'b0;
    model_t m0, m1;

    always #5 CLK = ~CLK;

    assign ideal0 = {a0 | b0 | c0, a0 & b0 & c0, ~(a0 | b0 | c0)};
    assign y0     = ((ideal0 & ~sa0) | sa1) ^ {2'b00, flip & ({a0, b0, c0} == 3'd3)};
    assign y1     = ~{a1 | b1 | c1, a1 & b1 & c1, ~(a1 | b1 | c1)};

    cell3_bist_seq dut0 (
        .CLK(CLK), .RST(RST), .START(START),
        .A(a0), .B(b0), .C(c0), .Y_IN(y0),
        .BUSY(busy0), .DONE(done0), .PASS(pass0), .FAIL_MASK(fm0),
`ifdef CELL3_BIST_MISR_EN
        .SIGNATURE(sig0),
`endif
        .ERR_CNT(err0)
    );

    cell3_bist_seq #(.ERR_W(3)) dut1 (
        .CLK(CLK), .RST(RST), .START(START),
        .A(a1), .B(b1), .C(c1), .Y_IN(y1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_MASK(fm1),
`ifdef CELL3_BIST_MISR_EN
        .SIGNATURE(sig1),
`endif
        .ERR_CNT(err1)
    );

    // Next model state from the run timeline: t=0 idle, 1..RUN_LEN active,
    // RUN_LEN+1 is the done cycle. Each pattern spans S+1 cycles, last one samples.
    function automatic model_t step(model_t m, logic rst, logic st, logic [2:0] y, int cap);
        model_t     n;
        int         p;
        logic [23:0] tt;
        n  = m;
        tt = TRUTH;
        if (rst) begin
            n.t = 0; n.fm = 3'b000; n.err = 0; n.pass = 1'b0; n.sig = 16'hFFFF;
        end else if (m.t == 0) begin
            if (st) begin
                n.t = 1; n.fm = 3'b000; n.err = 0; n.pass = 1'b0; n.sig = 16'hFFFF;
            end
        end else if (m.t == RUN_LEN + 1) begin
            n.t = 0;
        end else begin
            p = (m.t - 1) / (S + 1);
            if ((m.t - 1) % (S + 1) == S) begin
                for (int k = 0; k < 3; k++) begin
                    if (y[k] != tt[8*k + p]) begin
                        n.fm[k] = 1'b1;
                        n.err   = n.err + 1;
                    end
                end
                if (n.err > cap) n.err = cap;
                n.sig = {m.sig[14:0], 1'b0} ^ (m.sig[15] ? 16'h1021 : 16'h0000) ^ {13'd0, y};
            end
            n.t = m.t + 1;
            if (n.t == RUN_LEN + 1) n.pass = (n.fm == 3'b000);
        end
        return n;
    endfunction

    function automatic logic [2:0] exp_abc(int t);
        if (t >= 1 && t <= RUN_LEN) return 3'((t - 1) / (S + 1));
        return 3'b000;
    endfunction

    function automatic logic exp_busy(int t);
        return (t >= 1 && t <= RUN_LEN);
    endfunction

    always @(posedge CLK) begin
        m0 <= step(m0, RST, START, y0, 255);
        m1 <= step(m1, RST, START, y1, 7);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison of both DUTs against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            chk("dut0.ABC",  32'({a0, b0, c0}), 32'(exp_abc(m0.t)));
            chk("dut0.BUSY", 32'(busy0), 32'(exp_busy(m0.t)));
            chk("dut0.DONE", 32'(done0), 32'(m0.t == RUN_LEN + 1));
            chk("dut0.PASS", 32'(pass0), 32'(m0.pass));
            chk("dut0.MASK", 32'(fm0),   32'(m0.fm));
            chk("dut0.ERR",  32'(err0),  32'(m0.err));
            chk("dut1.ABC",  32'({a1, b1, c1}), 32'(exp_abc(m1.t)));
            chk("dut1.BUSY", 32'(busy1), 32'(exp_busy(m1.t)));
            chk("dut1.DONE", 32'(done1), 32'(m1.t == RUN_LEN + 1));
            chk("dut1.PASS", 32'(pass1), 32'(m1.pass));
            chk("dut1.MASK", 32'(fm1),   32'(m1.fm));
            chk("dut1.ERR",  32'(err1),  32'(m1.err));
`ifdef CELL3_BIST_MISR_EN
            chk("dut0.SIG",  32'(sig0),  32'(m0.sig));
            chk("dut1.SIG",  32'(sig1),  32'(m1.sig));
`endif
        end
    end

    // One run: START at cycle 0; optional extra START pulses and a reset cycle.
    // Cycle k is observed at the k-th falling edge after START is raised.
    task automatic run(input int restart_a, input int restart_b, input int rst_at,
                       output int done_cyc);
        done_cyc = 0;
        @(negedge CLK);
        START = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            @(negedge CLK);
            START = 1'b0;
            RST   = 1'b0;
            if (done0 && done_cyc == 0) done_cyc = k;
            if (rst_at > 0 && k == rst_at + 1) begin
                chk("rst.ABC",  32'({a0, b0, c0}), 32'd0);
                chk("rst.BUSY", 32'(busy0), 32'd0);
                chk("rst.MASK", 32'(fm0), 32'd0);
                chk("rst.ERR",  32'(err0), 32'd0);
            end
            if (k == restart_a || k == restart_b) START = 1'b1;
            if (k == rst_at) RST = 1'b1;
        end
        START = 1'b0;
        RST   = 1'b0;
    endtask

    task automatic results(input string name, input int done_cyc, input logic [2:0] mask,
                           input int err, input logic pass);
        $display("run %s: done@%0d mask=%b err=%0d pass=%b", name, done_cyc, fm0, err0, pass0);
        chk({name, ".done_cycle"}, 32'(done_cyc), 32'(RUN_LEN + 1));
        chk({name, ".mask"}, 32'(fm0), 32'(mask));
        chk({name, ".err"},  32'(err0), 32'(err));
        chk({name, ".pass"}, 32'(pass0), 32'(pass));
        chk({name, ".sat_err"},  32'(err1), 32'd7);
        chk({name, ".sat_mask"}, 32'(fm1), 32'h7);
    endtask

    initial begin
        int dc;
`ifdef CELL3_BIST_MISR_EN
        logic [15:0] s_ref;
`endif
        RST = 1'b1; START = 1'b0; sa0 = 3'b000; sa1 = 3'b000; flip = 1'b0;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        chk("reset.ABC",  32'({a0, b0, c0}), 32'd0);
        chk("reset.BUSY", 32'(busy0), 32'd0);
        chk("reset.DONE", 32'(done0), 32'd0);
        chk("reset.PASS", 32'(pass0), 32'd0);
        chk("reset.MASK", 32'(fm0),   32'd0);
        chk("reset.ERR",  32'(err0),  32'd0);
        RST = 1'b0;

        run(0, 0, 0, dc);  results("ideal", dc, 3'b000, 0, 1'b1);
        sa0 = 3'b010;
        run(0, 0, 0, dc);  results("c1_sa0", dc, 3'b010, 1, 1'b0);
        sa0 = 3'b100;
        run(0, 0, 0, dc);  results("c2_sa0", dc, 3'b100, 7, 1'b0);
        sa1 = 3'b001;
        run(0, 0, 0, dc);  results("c2_sa0_c0_sa1", dc, 3'b101, 14, 1'b0);
        sa0 = 3'b000; sa1 = 3'b000;
        run(5, 25, 0, dc); results("restart_ignored", dc, 3'b000, 0, 1'b1);

        sa0 = 3'b010;
        run(0, 0, 10, dc);
        $display("run reset_mid: done@%0d", dc);
        chk("reset_mid.no_done", 32'(dc), 32'd0);
        chk("reset_mid.pass", 32'(pass0), 32'd0);
        sa0 = 3'b000;

`ifdef CELL3_BIST_MISR_EN
        run(0, 0, 0, dc);  results("misr_a", dc, 3'b000, 0, 1'b1);
        s_ref = sig0;
        run(0, 0, 0, dc);  results("misr_b", dc, 3'b000, 0, 1'b1);
        chk("misr.repeat", 32'(sig0), 32'(s_ref));
        flip = 1'b1;
        run(0, 0, 0, dc);
        flip = 1'b0;
        n_vec++;
        if (sig0 == s_ref) begin
            n_err++;
            $display("FAIL misr.flip: got %0h expected a value other than %0h", sig0, s_ref);
        end
        $display("run misr_flip: sig=%0h ref=%0h", sig0, s_ref);
`endif

        repeat (2) @(negedge CLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
